ls_microsequencer: RTL and testbench

//   Registered, parametrised load/store sequencer for the control unit; successor to the combinational encoder.

---
 rtl/ls_seq_pkg.sv | 44 ++++
 rtl/ls_field_decode.sv | 18 +
 rtl/ls_microsequencer.sv | 142 ++++++++++++++
 tb/tb_ls_microsequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ls_seq_pkg.sv
// Shared definitions for the load/store microsequencer: FSM states, phase codes
// and ARM load/store instruction field positions.
package ls_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_MEM  = 2'd1;
  localparam logic [1:0] PH_WB   = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

  localparam int R25 = 25;
  localparam int P24 = 24;
  localparam int U23 = 23;
  localparam int B22 = 22;
  localparam int W21 = 21;
  localparam int L20 = 20;

  localparam logic [1:0] LS_OP = 2'b01;

  // Class vector layout {R,L,P,W,B,U}, MSB first.
  localparam int CLS_R = 5;
  localparam int CLS_L = 4;
  localparam int CLS_P = 3;
  localparam int CLS_W = 2;
  localparam int CLS_B = 1;
  localparam int CLS_U = 0;

  function automatic logic [1:0] phase_of(state_t s);
    case (s)
      S_MEM:   return PH_MEM;
      S_WB:    return PH_WB;
      S_DONE:  return PH_DONE;
      default: return PH_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/ls_field_decode.sv
// Combinational decode of an ARM single data transfer word into the
// load/store flag and the {R,L,P,W,B,U} class vector.
module ls_field_decode
  import ls_seq_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic        is_ls_o,
  output logic [5:0]  cls_o
);

  logic unused_bits;
  assign unused_bits = ^{instr_i[31:28], instr_i[19:0]};

  assign is_ls_o = (instr_i[27:26] == LS_OP);
  assign cls_o   = {instr_i[R25], instr_i[L20], instr_i[P24],
                    instr_i[W21], instr_i[B22], instr_i[U23]};

endmodule

// File: rtl/ls_microsequencer.sv
// Registered load/store microsequencer: IDLE->ADDR->MEM->[WB]->DONE.
// Define LS_MOC_TIMEOUT_EN to abort a MEM phase after MOC_TIMEOUT cycles without moc.
module ls_microsequencer
  import ls_seq_pkg::*;
#(
  parameter int STATE_W     = 10,
  parameter int STATE_BASE  = 16,
  parameter int MOC_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        instruction,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               moc,
  output logic [STATE_W-1:0] state_number,
  output logic               mem_en,
  output logic               mem_rw,
  output logic               byte_mode,
  output logic               add_sub,
  output logic               reg_offset,
  output logic               wb_en,
  output logic               done,
  output logic               decode_err,
  output logic               timeout_err
);

  if (STATE_BASE + 255 >= 2**STATE_W) begin : g_bad_state_w
    $error("ls_microsequencer: STATE_W too narrow for STATE_BASE+255");
  end
  if (STATE_BASE < 1) begin : g_bad_base
    $error("ls_microsequencer: STATE_BASE must be >= 1");
  end
  if (MOC_TIMEOUT < 1) begin : g_bad_timeout
    $error("ls_microsequencer: MOC_TIMEOUT must be >= 1");
  end

  state_t             state_q, state_d;
  logic [5:0]         cls_q, cls_d;
  logic               dec_err_d;
  logic               is_ls;
  logic [5:0]         dec_cls;
  logic               tmo_hit;
  logic [STATE_W-1:0] state_number_q;
  logic               instr_ready_q, mem_en_q, wb_en_q, done_q, decode_err_q;

  ls_field_decode u_decode (
    .instr_i (instruction),
    .is_ls_o (is_ls),
    .cls_o   (dec_cls)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    dec_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          if (is_ls) begin
            state_d = S_ADDR;
            cls_d   = dec_cls;
          end else begin
            dec_err_d = 1'b1;
          end
        end
      end
      S_ADDR: state_d = S_MEM;
      S_MEM: begin
        // moc takes priority over a timeout landing in the same cycle.
        if (moc) begin
          state_d = (!cls_q[CLS_P] || cls_q[CLS_W]) ? S_WB : S_DONE;
        end else if (tmo_hit) begin
          state_d = S_IDLE;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      cls_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cls_q          <= '0;
      state_number_q <= '0;
      instr_ready_q  <= 1'b1;
      mem_en_q       <= 1'b0;
      wb_en_q        <= 1'b0;
      done_q         <= 1'b0;
      decode_err_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cls_q          <= cls_d;
      state_number_q <= (state_d == S_IDLE) ? '0 :
                        STATE_W'(STATE_BASE) + STATE_W'({cls_d, phase_of(state_d)});
      instr_ready_q  <= (state_d == S_IDLE);
      mem_en_q       <= (state_d == S_MEM);
      wb_en_q        <= (state_d == S_WB);
      done_q         <= (state_d == S_DONE);
      decode_err_q   <= dec_err_d;
    end
  end

`ifdef LS_MOC_TIMEOUT_EN
  localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);
  logic [CNT_W-1:0] mem_cnt_q;

  // mem_cnt_q holds the 1-based index of the current MEM cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_cnt_q <= '0;
    end else if (state_d == S_MEM && state_q != S_MEM) begin
      mem_cnt_q <= CNT_W'(1);
    end else if (state_d == S_MEM) begin
      mem_cnt_q <= mem_cnt_q + CNT_W'(1);
    end
  end

  assign tmo_hit     = (state_q == S_MEM) && (mem_cnt_q == CNT_W'(MOC_TIMEOUT));
  assign timeout_err = tmo_hit && !moc;
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign state_number = state_number_q;
  assign instr_ready  = instr_ready_q;
  assign mem_en       = mem_en_q;
  assign wb_en        = wb_en_q;
  assign done         = done_q;
  assign decode_err   = decode_err_q;
  assign mem_rw       = cls_q[CLS_L];
  assign byte_mode    = cls_q[CLS_B];
  assign add_sub      = cls_q[CLS_U];
  assign reg_offset   = cls_q[CLS_R];

endmodule

// File: tb/tb_ls_microsequencer.sv
// Directed bench for ls_microsequencer; compile with LS_MOC_TIMEOUT_EN to
// exercise the MEM-phase timeout instead of the indefinite wait.
module tb_ls_microsequencer;

`ifdef LS_MOC_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  localparam logic [31:0] W_STR  = 32'hE580_1004;
  localparam logic [31:0] W_LDRB = 32'hE450_1001;
  localparam logic [31:0] W_ADD  = 32'hE081_1002;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        moc;
  logic [9:0]  state_number;
  logic        mem_en, mem_rw, byte_mode, add_sub, reg_offset;
  logic        wb_en, done, decode_err, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  ls_microsequencer #(
    .STATE_W     (10),
    .STATE_BASE  (16),
    .MOC_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .moc          (moc),
    .state_number (state_number),
    .mem_en       (mem_en),
    .mem_rw       (mem_rw),
    .byte_mode    (byte_mode),
    .add_sub      (add_sub),
    .reg_offset   (reg_offset),
    .wb_en        (wb_en),
    .done         (done),
    .decode_err   (decode_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp5 [9] = '{52, 53, 55, 0, 88, 89, 90, 91, 0};
  int done_cnt;

  initial begin
    reset_n     = 1'b0;
    instruction = 32'h0;
    instr_valid = 1'b0;
    moc         = 1'b0;
    #12;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_state", 32'(state_number), 32'd0);
    chk("rst_outs", 32'({mem_en, mem_rw, byte_mode, add_sub, reg_offset,
                         wb_en, done, decode_err, timeout_err}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Test 1: STR r1,[r0,#4], moc in second MEM cycle
    instruction = W_STR; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("t1_addr", 32'(state_number), 32'd52);
    chk("t1_ready", 32'(instr_ready), 32'd0);
    chk("t1_addsub", 32'(add_sub), 32'd1);
    tick();
    chk("t1_mem1", 32'(state_number), 32'd53);
    chk("t1_mem_en", 32'(mem_en), 32'd1);
    chk("t1_mem_rw", 32'(mem_rw), 32'd0);
    tick();
    chk("t1_mem2", 32'(state_number), 32'd53);
    chk("t1_wb_mem2", 32'(wb_en), 32'd0);
    moc = 1'b1;
    tick();
    moc = 1'b0;
    chk("t1_done_state", 32'(state_number), 32'd55);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_wb", 32'(wb_en), 32'd0);
    chk("t1_mem_en_off", 32'(mem_en), 32'd0);
    tick();
    chk("t1_idle", 32'(state_number), 32'd0);
    chk("t1_idle_ready", 32'(instr_ready), 32'd1);
    chk("t1_idle_done", 32'(done), 32'd0);

    // Test 2: LDRB r1,[r0],#-1, moc immediate, writeback taken
    instruction = W_LDRB; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("t2_addr", 32'(state_number), 32'd88);
    chk("t2_rw", 32'(mem_rw), 32'd1);
    chk("t2_byte", 32'(byte_mode), 32'd1);
    chk("t2_addsub", 32'(add_sub), 32'd0);
    chk("t2_regoff", 32'(reg_offset), 32'd0);
    moc = 1'b1;
    tick();
    chk("t2_mem", 32'(state_number), 32'd89);
    chk("t2_mem_en", 32'(mem_en), 32'd1);
    tick();
    moc = 1'b0;
    chk("t2_wb_state", 32'(state_number), 32'd90);
    chk("t2_wb_en", 32'(wb_en), 32'd1);
    chk("t2_wb_byte", 32'(byte_mode), 32'd1);
    tick();
    chk("t2_done_state", 32'(state_number), 32'd91);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_done_rw", 32'(mem_rw), 32'd1);
    tick();
    chk("t2_idle", 32'(state_number), 32'd0);
    chk("t2_idle_flags", 32'({mem_rw, byte_mode, add_sub, reg_offset}), 32'd0);

    // Test 3: ADD is rejected
    instruction = W_ADD; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("t3_decerr", 32'(decode_err), 32'd1);
    chk("t3_ready", 32'(instr_ready), 32'd1);
    chk("t3_state", 32'(state_number), 32'd0);
    tick();
    chk("t3_decerr_pulse", 32'(decode_err), 32'd0);
    chk("t3_state2", 32'(state_number), 32'd0);

    // Test 4: asynchronous reset during MEM
    instruction = W_LDRB; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("t4_in_mem", 32'(mem_en), 32'd1);
    reset_n = 1'b0;
    #2;
    chk("t4_rst_mem_en", 32'(mem_en), 32'd0);
    chk("t4_rst_state", 32'(state_number), 32'd0);
    chk("t4_rst_ready", 32'(instr_ready), 32'd1);
    reset_n = 1'b1;
    instruction = W_STR; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("t4_reaccept", 32'(state_number), 32'd52);
    moc = 1'b1;
    repeat (3) tick();
    moc = 1'b0;
    chk("t4_idle", 32'(state_number), 32'd0);

    // Test 5: back-to-back with instr_valid held; moc held high throughout
    instruction = W_STR; instr_valid = 1'b1; moc = 1'b1;
    done_cnt = 0;
    tick();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) instruction = W_LDRB;
      if (i == 4) instr_valid = 1'b0;
      chk($sformatf("t5_seq%0d", i), 32'(state_number), 32'(exp5[i]));
      if (done) done_cnt++;
      tick();
    end
    moc = 1'b0;
    chk("t5_done_count", 32'(done_cnt), 32'd2);
    chk("t5_final_idle", 32'(state_number), 32'd0);

    // Test 6: moc never arrives
    instruction = W_STR; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    done_cnt = 0;
`ifdef LS_MOC_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t6_mem%0d", k), 32'(state_number), 32'd53);
      chk($sformatf("t6_tmo%0d", k), 32'(timeout_err), 32'(k == 8));
    end
    tick();
    chk("t6_idle", 32'(state_number), 32'd0);
    chk("t6_ready", 32'(instr_ready), 32'd1);
    chk("t6_tmo_off", 32'(timeout_err), 32'd0);
    chk("t6_mem_en_off", 32'(mem_en), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("t6_no_done", 32'(done_cnt), 32'd0);
`else
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("t6_wait%0d", k), 32'(state_number), 32'd53);
      chk($sformatf("t6_tmo%0d", k), 32'(timeout_err), 32'd0);
    end
    moc = 1'b1;
    tick();
    moc = 1'b0;
    chk("t6_late_done", 32'(done), 32'd1);
    tick();
    chk("t6_idle", 32'(state_number), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
